// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter: four-port arbiter in front of the single-port 32-bit main
// video RAM. It grants at most one access per clock, muxes the winner onto
// the RAM and steers the read data back to the winning port one cycle later.
// Port 0 is the CPU/host, 1 and 2 are the layer renderers, 3 is the sprite
// renderer.
module main_ram_arbiter #(
  parameter int PORT0_PRIORITY = 0,
  parameter int ADDR_W         = 15
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wrdata,
  input  logic [3:0]        p0_wrbytesel,
  input  logic              p0_write,
  input  logic              p0_strobe,
  output logic              p0_ack,
  output logic              p0_rdvalid,

  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wrdata,
  input  logic [3:0]        p1_wrbytesel,
  input  logic              p1_write,
  input  logic              p1_strobe,
  output logic              p1_ack,
  output logic              p1_rdvalid,

  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [31:0]       p2_wrdata,
  input  logic [3:0]        p2_wrbytesel,
  input  logic              p2_write,
  input  logic              p2_strobe,
  output logic              p2_ack,
  output logic              p2_rdvalid,

  input  logic [ADDR_W-1:0] p3_addr,
  input  logic [31:0]       p3_wrdata,
  input  logic [3:0]        p3_wrbytesel,
  input  logic              p3_write,
  input  logic              p3_strobe,
  output logic              p3_ack,
  output logic              p3_rdvalid,

  output logic [31:0]       rddata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic [3:0]        ram_wrbytesel,
  output logic              ram_write,
  input  logic [31:0]       ram_rddata
);

  localparam bit PRIO0 = (PORT0_PRIORITY != 0);

  logic [3:0] strobe_vec;
  logic [3:0] write_vec;

  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  logic [1:0] last_grant_q, last_grant_d;
  logic       rd_pend_q, rd_pend_d;
  logic [1:0] rd_port_q, rd_port_d;

  assign strobe_vec = {p3_strobe, p2_strobe, p1_strobe, p0_strobe};
  assign write_vec  = {p3_write, p2_write, p1_write, p0_write};

  // Pick the winner: optional fixed priority for port 0, otherwise a
  // round-robin scan starting just after the last granted port. Arbitration
  // is masked while reset is asserted.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    if (rst_n) begin
      if (PRIO0 && strobe_vec[0]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'd0;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          cand = last_grant_q + 2'(k);
          if (!grant_valid && strobe_vec[cand] && !(PRIO0 && cand == 2'd0)) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
          end
        end
      end
    end
  end

  assign p0_ack = grant_valid && (grant_idx == 2'd0);
  assign p1_ack = grant_valid && (grant_idx == 2'd1);
  assign p2_ack = grant_valid && (grant_idx == 2'd2);
  assign p3_ack = grant_valid && (grant_idx == 2'd3);

  // Steer the granted port onto the RAM; with no grant the index stays 0 so
  // port 0 values sit on the bus, and the write strobe is suppressed.
  always_comb begin
    ram_addr      = p0_addr;
    ram_wrdata    = p0_wrdata;
    ram_wrbytesel = p0_wrbytesel;
    case (grant_idx)
      2'd1: begin
        ram_addr      = p1_addr;
        ram_wrdata    = p1_wrdata;
        ram_wrbytesel = p1_wrbytesel;
      end
      2'd2: begin
        ram_addr      = p2_addr;
        ram_wrdata    = p2_wrdata;
        ram_wrbytesel = p2_wrbytesel;
      end
      2'd3: begin
        ram_addr      = p3_addr;
        ram_wrdata    = p3_wrdata;
        ram_wrbytesel = p3_wrbytesel;
      end
      default: begin
        ram_addr      = p0_addr;
        ram_wrdata    = p0_wrdata;
        ram_wrbytesel = p0_wrbytesel;
      end
    endcase
    ram_write = grant_valid && write_vec[grant_idx];
  end

  // Next round-robin pointer and read-in-flight tracking; a priority grant
  // to port 0 leaves the pointer alone so ports 1-3 keep their rotation.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_port_d    = rd_port_q;
    if (grant_valid) begin
      if (!(PRIO0 && grant_idx == 2'd0)) begin
        last_grant_d = grant_idx;
      end
      rd_pend_d = ~write_vec[grant_idx];
      rd_port_d = grant_idx;
    end
  end

  // State register; reset points the scan so port 0 is checked first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 2'd3;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 2'd0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
    end
  end

  assign p0_rdvalid = rd_pend_q && (rd_port_q == 2'd0);
  assign p1_rdvalid = rd_pend_q && (rd_port_q == 2'd1);
  assign p2_rdvalid = rd_pend_q && (rd_port_q == 2'd2);
  assign p3_rdvalid = rd_pend_q && (rd_port_q == 2'd3);

  assign rddata = ram_rddata;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// tb_main_ram_arbiter: directed checks of the main RAM arbiter against a
// write-first, one-cycle-latency RAM fixture. A second instance with port 0
// priority enabled is used for the priority-mode sequence.
module tb_main_ram_arbiter;

  logic clk;
  logic rst_n;

  logic [14:0] p_addr    [4];
  logic [31:0] p_wrdata  [4];
  logic [3:0]  p_bsel    [4];
  logic        p_write   [4];
  logic        p_strobe  [4];
  logic        p_ack     [4];
  logic        p_rdvalid [4];
  logic [31:0] rddata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  logic        q_strobe  [4];
  logic        q_ack     [4];
  logic        q_rdvalid [4];
  logic [31:0] q_rddata;
  logic [14:0] q_ram_addr;
  logic [31:0] q_ram_wrdata;
  logic [3:0]  q_ram_wrbytesel;
  logic        q_ram_write;
  logic [31:0] q_ram_rddata;
  logic [14:0] q_addr;
  logic [31:0] q_wrdata;
  logic [3:0]  q_bsel;
  logic        q_write;

  logic [3:0] ack_vec, rdv_vec, q_ack_vec, q_rdv_vec;

  logic [31:0] mem [0:32767];

  int checks = 0;
  int errors = 0;

  assign ack_vec   = {p_ack[3], p_ack[2], p_ack[1], p_ack[0]};
  assign rdv_vec   = {p_rdvalid[3], p_rdvalid[2], p_rdvalid[1], p_rdvalid[0]};
  assign q_ack_vec = {q_ack[3], q_ack[2], q_ack[1], q_ack[0]};
  assign q_rdv_vec = {q_rdvalid[3], q_rdvalid[2], q_rdvalid[1], q_rdvalid[0]};

  main_ram_arbiter #(.PORT0_PRIORITY(0), .ADDR_W(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p_addr[0]), .p0_wrdata(p_wrdata[0]), .p0_wrbytesel(p_bsel[0]),
    .p0_write(p_write[0]), .p0_strobe(p_strobe[0]), .p0_ack(p_ack[0]), .p0_rdvalid(p_rdvalid[0]),
    .p1_addr(p_addr[1]), .p1_wrdata(p_wrdata[1]), .p1_wrbytesel(p_bsel[1]),
    .p1_write(p_write[1]), .p1_strobe(p_strobe[1]), .p1_ack(p_ack[1]), .p1_rdvalid(p_rdvalid[1]),
    .p2_addr(p_addr[2]), .p2_wrdata(p_wrdata[2]), .p2_wrbytesel(p_bsel[2]),
    .p2_write(p_write[2]), .p2_strobe(p_strobe[2]), .p2_ack(p_ack[2]), .p2_rdvalid(p_rdvalid[2]),
    .p3_addr(p_addr[3]), .p3_wrdata(p_wrdata[3]), .p3_wrbytesel(p_bsel[3]),
    .p3_write(p_write[3]), .p3_strobe(p_strobe[3]), .p3_ack(p_ack[3]), .p3_rdvalid(p_rdvalid[3]),
    .rddata(rddata),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  main_ram_arbiter #(.PORT0_PRIORITY(1), .ADDR_W(15)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(q_addr), .p0_wrdata(q_wrdata), .p0_wrbytesel(q_bsel),
    .p0_write(q_write), .p0_strobe(q_strobe[0]), .p0_ack(q_ack[0]), .p0_rdvalid(q_rdvalid[0]),
    .p1_addr(q_addr), .p1_wrdata(q_wrdata), .p1_wrbytesel(q_bsel),
    .p1_write(q_write), .p1_strobe(q_strobe[1]), .p1_ack(q_ack[1]), .p1_rdvalid(q_rdvalid[1]),
    .p2_addr(q_addr), .p2_wrdata(q_wrdata), .p2_wrbytesel(q_bsel),
    .p2_write(q_write), .p2_strobe(q_strobe[2]), .p2_ack(q_ack[2]), .p2_rdvalid(q_rdvalid[2]),
    .p3_addr(q_addr), .p3_wrdata(q_wrdata), .p3_wrbytesel(q_bsel),
    .p3_write(q_write), .p3_strobe(q_strobe[3]), .p3_ack(q_ack[3]), .p3_rdvalid(q_rdvalid[3]),
    .rddata(q_rddata),
    .ram_addr(q_ram_addr), .ram_wrdata(q_ram_wrdata), .ram_wrbytesel(q_ram_wrbytesel),
    .ram_write(q_ram_write), .ram_rddata(q_ram_rddata)
  );

  // Free-running system clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  bsel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (bsel[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Write-first RAM fixture with one-cycle read latency; contents are
  // preloaded whenever reset is held so the directed reads have known data.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[15'h0010] <= 32'hDEADBEEF;
      mem[15'h0020] <= 32'hAABBCCDD;
      mem[15'h0100] <= 32'h10000000;
      mem[15'h0101] <= 32'h10000001;
      mem[15'h0102] <= 32'h10000002;
      mem[15'h0103] <= 32'h10000003;
    end else if (ram_write) begin
      mem[ram_addr] <= mergeBytes(mem[ram_addr], ram_wrdata, ram_wrbytesel);
    end
    ram_rddata <= ram_write ? mergeBytes(mem[ram_addr], ram_wrdata, ram_wrbytesel)
                            : mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic strobe, input logic write,
                               input logic [14:0] addr, input logic [31:0] data,
                               input logic [3:0] bsel);
    p_strobe[port] = strobe;
    p_write[port]  = write;
    p_addr[port]   = addr;
    p_wrdata[port] = data;
    p_bsel[port]   = bsel;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, single read, byte write, write/read hazard,
  // round-robin from reset, reset mid-read, then port-0 priority mode.
  initial begin
    int rr_order [6];
    logic [3:0] pr_ack [6];
    logic [3:0] pr_rdv [6];
    rr_order = '{0, 1, 2, 3, 0, 1};
    pr_ack   = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0100};
    pr_rdv   = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
      q_strobe[i] = 1'b0;
    end
    q_addr = 15'h0; q_wrdata = 32'h0; q_bsel = 4'h0; q_write = 1'b0;
    q_ram_rddata = 32'h0;
    applyStimulus(0, 1'b1, 1'b1, 15'h0005, 32'h12345678, 4'hF);

    $display("[TB] reset checks");
    @(negedge clk);
    checkOutput("reset_ack", {28'h0, ack_vec}, 32'h0);
    checkOutput("reset_ram_write", {31'h0, ram_write}, 32'h0);
    checkOutput("reset_rdvalid", {28'h0, rdv_vec}, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    rst_n = 1'b1;

    $display("[TB] single read on port 1");
    applyStimulus(1, 1'b1, 1'b0, 15'h0010, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_ack", {28'h0, ack_vec}, 32'h2);
    checkOutput("rd_ram_addr", {17'h0, ram_addr}, 32'h0010);
    checkOutput("rd_ram_write", {31'h0, ram_write}, 32'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_rdvalid", {28'h0, rdv_vec}, 32'h2);
    checkOutput("rd_rddata", rddata, 32'hDEADBEEF);
    nextCycle();

    $display("[TB] byte write on port 0 then read back");
    applyStimulus(0, 1'b1, 1'b1, 15'h0020, 32'h11223344, 4'b0101);
    @(negedge clk);
    checkOutput("bw_ack", {28'h0, ack_vec}, 32'h1);
    checkOutput("bw_ram_write", {31'h0, ram_write}, 32'h1);
    checkOutput("bw_bytesel", {28'h0, ram_wrbytesel}, 32'h5);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 15'h0020, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("bw_rd_ack", {28'h0, ack_vec}, 32'h1);
    checkOutput("bw_no_rdvalid", {28'h0, rdv_vec}, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("bw_rdvalid", {28'h0, rdv_vec}, 32'h1);
    checkOutput("bw_rddata", rddata, 32'hAA22CC44);
    nextCycle();

    $display("[TB] write then read same address from different ports");
    applyStimulus(2, 1'b1, 1'b1, 15'h7FFF, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    checkOutput("hz_wr_ack", {28'h0, ack_vec}, 32'h4);
    nextCycle();
    applyStimulus(2, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 15'h7FFF, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("hz_rd_ack", {28'h0, ack_vec}, 32'h2);
    checkOutput("hz_wr_no_rdvalid", {28'h0, rdv_vec}, 32'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("hz_rdvalid", {28'h0, rdv_vec}, 32'h2);
    checkOutput("hz_rddata", rddata, 32'hCAFEF00D);
    nextCycle();

    $display("[TB] round-robin with all ports strobing from reset");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 15'(16'h0100 + i), 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rr_reset_ack", {28'h0, ack_vec}, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_ack_%0d", c), {28'h0, ack_vec}, 32'h1 << rr_order[c]);
      checkOutput($sformatf("rr_addr_%0d", c), {17'h0, ram_addr}, 32'h0100 + rr_order[c]);
      if (c == 0) begin
        checkOutput("rr_rdvalid_0", {28'h0, rdv_vec}, 32'h0);
      end else begin
        checkOutput($sformatf("rr_rdvalid_%0d", c), {28'h0, rdv_vec}, 32'h1 << rr_order[c-1]);
        checkOutput($sformatf("rr_rddata_%0d", c), rddata, 32'h10000000 + rr_order[c-1]);
      end
      nextCycle();
    end

    $display("[TB] reset during an in-flight read on port 3");
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 15'h0103, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("mr_ack", {28'h0, ack_vec}, 32'h8);
    checkOutput("mr_prev_rdvalid", {28'h0, rdv_vec}, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_ack_masked", {28'h0, ack_vec}, 32'h0);
    checkOutput("mr_write_masked", {31'h0, ram_write}, 32'h0);
    nextCycle();
    for (int i = 1; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 15'(16'h0100 + i), 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("mr_no_rdvalid", {28'h0, rdv_vec}, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mr_first_grant", {28'h0, ack_vec}, 32'h2);
    checkOutput("mr_rdvalid_after", {28'h0, rdv_vec}, 32'h0);
    nextCycle();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);

    $display("[TB] port 0 priority mode");
    q_strobe[0] = 1'b1;
    q_strobe[2] = 1'b1;
    q_strobe[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) q_strobe[0] = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("pr_ack_%0d", c), {28'h0, q_ack_vec}, {28'h0, pr_ack[c]});
      checkOutput($sformatf("pr_rdvalid_%0d", c), {28'h0, q_rdv_vec}, {28'h0, pr_rdv[c]});
      nextCycle();
    end
    for (int i = 0; i < 4; i++) q_strobe[i] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
